mulalu: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage.
- It is the consumer of the single-cycle ALU's mulalu_sign/mulalu_func request and the producer of the HI/LO register writes.
- It stalls the pipeline while an iterative operation runs, then writes HI/LO for one cycle.
- Shift-add multiply; restoring divide; signed operations are handled by magnitude-then-fixup.

---
 rtl/mulalu_pkg.sv | 31 +++
 rtl/mulalu_divider.sv | 52 +++++
 rtl/mulalu.sv | 205 ++++++++++++++++++++
 tb/tb_mulalu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mulalu_pkg.sv
// mulalu_pkg: shared types and constants for the multi-cycle multiply/divide unit.
// FUNC_* / W_* mirror the codebase-wide definitions in defines.vh so the
// unit and its bench can be compiled without an include path.
package mulalu_pkg;

   localparam int unsigned W_DATA = 32;
   localparam int unsigned W_FUNC = 5;

   localparam logic [W_FUNC-1:0] FUNC_NONE = 5'b00000;
   localparam logic [W_FUNC-1:0] FUNC_MUL  = 5'b00001;
   localparam logic [W_FUNC-1:0] FUNC_DIV  = 5'b00010;

   // Counter value of the final iteration step (32 steps: 0..31)
   localparam logic [4:0]  ITER_LAST = 5'd31;
   // Quotient reported for a divide by zero
   localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Two's-complement magnitude; 0x8000_0000 maps to itself, which is the
   // correct unsigned magnitude 2^31.
   function automatic logic [31:0] magnitude(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mulalu_divider.sv
// mulalu_divider: restoring-divide iteration datapath, one quotient bit per step.
// load seeds the partial remainder with 0 and the quotient register with the
// dividend; each step shifts one dividend bit into the remainder and keeps
// the trial subtraction only if it does not go negative.
module mulalu_divider
   import mulalu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH:0]   trial;

   // Trial subtraction of the divisor from the shifted partial remainder;
   // the top bit is set exactly when the result would be negative.
   always_comb begin
      trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor};
   end

   // Remainder/quotient shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
      end else if (step) begin
         if (!trial[WIDTH]) begin
            rem_q <= trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/mulalu.sv
// mulalu: multi-cycle multiply/divide unit (EX stage), writes HI/LO.
// Shift-add multiply and restoring divide on operand magnitudes, with the
// sign applied combinationally at write time. Stalls the pipeline while an
// iteration is in flight.
// Optional build macro: MULALU_FAST_MUL_EN -- single-cycle 33x33 multiply.
module mulalu
   import mulalu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mulalu_sign,
   input  logic [W_FUNC-1:0] mulalu_func,
   input  logic [WIDTH-1:0]  source_a,
   input  logic [WIDTH-1:0]  source_b,
   input  logic              flush,
   output logic              stall,
   output logic              hi_write,
   output logic [WIDTH-1:0]  hi_write_data,
   output logic              lo_write,
   output logic [WIDTH-1:0]  lo_write_data
);

   state_t             state, state_nx;
   logic [4:0]         count;

   logic               req_mul, req_div, req_any, div_by_zero, accept;
   logic [WIDTH-1:0]   mag_a, mag_b;

   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   divisor_q;
   logic [2*WIDTH-1:0] prod_q;
   logic               neg_q, neg_r, op_div_q, div0_q;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_signed;
   logic               div_load, div_step;
   logic [WIDTH-1:0]   quo, rem;

`ifdef MULALU_FAST_MUL_EN
   logic signed [WIDTH:0]     fast_a, fast_b;
   logic signed [2*WIDTH+1:0] fast_p;
`endif

   // Request decode and operand magnitudes
   always_comb begin
      req_mul     = (mulalu_func == FUNC_MUL);
      req_div     = (mulalu_func == FUNC_DIV);
      req_any     = req_mul | req_div;
      div_by_zero = req_div & (source_b == '0);
      accept      = (state == IDLE) & req_any & ~flush;
      mag_a       = mulalu_sign ? magnitude(source_a) : source_a;
      mag_b       = mulalu_sign ? magnitude(source_b) : source_b;
   end

`ifdef MULALU_FAST_MUL_EN
   // Single-cycle product of the sign- or zero-extended operands
   always_comb begin
      fast_a = {mulalu_sign & source_a[WIDTH-1], source_a};
      fast_b = {mulalu_sign & source_b[WIDTH-1], source_b};
      fast_p = fast_a * fast_b;
   end
`endif

   // Next-state, stall and divider control
   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      div_load = 1'b0;
      div_step = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               stall = 1'b1;
               if (req_mul) begin
`ifdef MULALU_FAST_MUL_EN
                  state_nx = DONE;
`else
                  state_nx = MUL;
`endif
               end else if (div_by_zero) begin
                  state_nx = DONE;
               end else begin
                  state_nx = DIV;
                  div_load = 1'b1;
               end
            end
         end
         MUL: begin
            if (flush) begin
               state_nx = IDLE;
            end else begin
               stall = 1'b1;
               if (count == ITER_LAST) state_nx = DONE;
            end
         end
         DIV: begin
            if (flush) begin
               state_nx = IDLE;
            end else begin
               stall    = 1'b1;
               div_step = 1'b1;
               if (count == ITER_LAST) state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      // Outputs are quiet for the whole time reset is held, even if the
      // upstream stage keeps presenting a request.
      if (rst) stall = 1'b0;
   end

   // State register and iteration counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nx;
         if ((state == MUL || state == DIV) && state_nx == state)
            count <= count + 5'd1;
         else
            count <= '0;
      end
   end

   // One shift-add step: conditionally add the multiplicand to the upper
   // half, then shift the whole product register right by one.
   always_comb begin
      mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   end

   // Operand capture at acceptance and multiply iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q   <= '0;
         divisor_q <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         op_div_q  <= 1'b0;
         div0_q    <= 1'b0;
      end else if (accept) begin
         op_div_q  <= req_div;
         div0_q    <= div_by_zero;
         // A divide by zero reports the raw dividend, so no sign fixup and
         // the unmodified source_a is kept (mcand_q is otherwise idle on DIV).
         neg_q     <= mulalu_sign & (source_a[WIDTH-1] ^ source_b[WIDTH-1]) & ~div_by_zero;
         neg_r     <= mulalu_sign & source_a[WIDTH-1] & ~div_by_zero;
         mcand_q   <= div_by_zero ? source_a : mag_a;
         divisor_q <= mag_b;
         prod_q    <= {{WIDTH{1'b0}}, mag_b};
`ifdef MULALU_FAST_MUL_EN
         if (req_mul) begin
            prod_q <= fast_p[2*WIDTH-1:0];
            neg_q  <= 1'b0;
         end
`endif
      end else if (state == MUL && !flush) begin
         prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
      end
   end

   mulalu_divider #(
      .WIDTH (WIDTH)
   ) u_divider (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (divisor_q),
      .quotient  (quo),
      .remainder (rem)
   );

   // Write strobes and sign-fixed write data in DONE
   always_comb begin
      prod_signed   = neg_q ? ({(2*WIDTH){1'b0}} - prod_q) : prod_q;
      hi_write      = (state == DONE) & ~flush;
      lo_write      = (state == DONE) & ~flush;
      hi_write_data = '0;
      lo_write_data = '0;
      if (state == DONE) begin
         if (div0_q) begin
            hi_write_data = mcand_q;
            lo_write_data = DIV0_LO;
         end else if (op_div_q) begin
            hi_write_data = neg_r ? ('0 - rem) : rem;
            lo_write_data = neg_q ? ('0 - quo) : quo;
         end else begin
            hi_write_data = prod_signed[2*WIDTH-1:WIDTH];
            lo_write_data = prod_signed[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mulalu.sv
// tb_mulalu: directed table, random model comparison and corner sequences
// (flush, reset, back-to-back) for the mulalu multiply/divide unit.
module tb_mulalu;
   import mulalu_pkg::*;

   logic              clk, rst, mulalu_sign, flush;
   logic [W_FUNC-1:0] mulalu_func;
   logic [31:0]       source_a, source_b;
   logic              stall, hi_write, lo_write;
   logic [31:0]       hi_write_data, lo_write_data;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       nm;
      logic        sg;
      logic [4:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   mulalu #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .mulalu_sign   (mulalu_sign),
      .mulalu_func   (mulalu_func),
      .source_a      (source_a),
      .source_b      (source_b),
      .flush         (flush),
      .stall         (stall),
      .hi_write      (hi_write),
      .hi_write_data (hi_write_data),
      .lo_write      (lo_write),
      .lo_write_data (lo_write_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Cycle on which the write strobes are expected (cycle 0 = request cycle)
   function automatic int lat_of(input logic [4:0] fn, input logic [31:0] b);
      if (fn == FUNC_DIV && b == 32'd0) return 1;
`ifdef MULALU_FAST_MUL_EN
      if (fn == FUNC_MUL) return 1;
`endif
      return 33;
   endfunction

   // Architectural result from plain arithmetic
   task automatic model(input logic sg, input logic [4:0] fn, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
      longint      sp;
      logic [63:0] up;
      int          sa, sb;
      sa = a;
      sb = b;
      if (fn == FUNC_MUL) begin
         if (sg) begin
            sp = longint'(sa) * longint'(sb);
            up = sp;
         end else begin
            up = 64'(a) * 64'(b);
         end
         hi = up[63:32];
         lo = up[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
         end else begin
            lo = sa / sb;
            hi = sa % sb;
         end
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endtask

   // Present one request at posedge+1 of cycle 0 and watch it to completion.
   // Returns at posedge+1 of cycle lat+tail+1; with tail==0 the caller can
   // present the next request in the cycle right after DONE.
   task automatic run_op(input string nm, input logic sg, input logic [4:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int tail);
      int          lat;
      int          stall_bad, done_cyc, writes, pair_bad;
      logic [31:0] ghi, glo;
      lat = lat_of(fn, b);
      stall_bad = 0; done_cyc = -1; writes = 0; pair_bad = 0;
      ghi = '0; glo = '0;
      mulalu_sign = sg; mulalu_func = fn; source_a = a; source_b = b; flush = 1'b0;
      for (int cyc = 0; cyc <= lat + tail; cyc++) begin
         #1;
         if (stall !== (cyc < lat)) stall_bad++;
         if (hi_write !== lo_write) pair_bad++;
         if (hi_write === 1'b1) begin
            writes++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               ghi = hi_write_data;
               glo = lo_write_data;
            end
         end
         if (cyc == lat && tail > 0) mulalu_func = FUNC_NONE;
         @(posedge clk);
         #1;
      end
      chk({nm, " stall"}, 64'(stall_bad), 64'd0);
      chk({nm, " done_cycle"}, 64'(done_cyc), 64'(lat));
      chk({nm, " hi"}, {32'd0, ghi}, {32'd0, ehi});
      chk({nm, " lo"}, {32'd0, glo}, {32'd0, elo});
      chk({nm, " one_write"}, 64'(writes), 64'd1);
      chk({nm, " strobe_pair"}, 64'(pair_bad), 64'd0);
   endtask

   initial begin
      vec_t        vecs[8];
      logic [31:0] rhi, rlo, ra, rb;
      logic        rsg;
      logic [4:0]  rfn;
      int          w;

      vecs[0] = '{"smul_neg2x3",  1'b1, FUNC_MUL, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{"umul_max",     1'b0, FUNC_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{"sdiv_m7_2",    1'b1, FUNC_DIV, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{"udiv_7_2",     1'b0, FUNC_DIV, 32'd7,         32'd2,        32'd1,         32'd3};
      vecs[4] = '{"sdiv_min_m1",  1'b1, FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
      vecs[5] = '{"udiv_5_0",     1'b0, FUNC_DIV, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
      vecs[6] = '{"sdiv_m7_0",    1'b1, FUNC_DIV, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
      vecs[7] = '{"smul_min_min", 1'b1, FUNC_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

      rst = 1'b1; flush = 1'b0; mulalu_sign = 1'b0; mulalu_func = FUNC_NONE;
      source_a = '0; source_b = '0;
      #1;
      chk("reset stall",   {63'd0, stall}, 64'd0);
      chk("reset strobes", {62'd0, hi_write, lo_write}, 64'd0);
      chk("reset data",    {hi_write_data, lo_write_data}, 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table
      foreach (vecs[i])
         run_op(vecs[i].nm, vecs[i].sg, vecs[i].fn, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, 2);

      // Back-to-back: second request presented in the cycle after DONE
      run_op("b2b_first",  1'b0, FUNC_MUL, 32'd1234, 32'd5678, 32'd0, 32'd7006652, 0);
      run_op("b2b_second", 1'b1, FUNC_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 2);

      // Flush in cycle 10 of a DIV, new MUL accepted in cycle 11
      mulalu_sign = 1'b0; mulalu_func = FUNC_DIV; source_a = 32'd100; source_b = 32'd7;
      w = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (hi_write !== 1'b0 || lo_write !== 1'b0 || stall !== 1'b1) w++;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      if (hi_write !== 1'b0 || lo_write !== 1'b0) w++;
      chk("flush_div stall", {63'd0, stall}, 64'd0);
      chk("flush_div pre", 64'(w), 64'd0);
      @(posedge clk); #1;
      run_op("after_flush_mul", 1'b0, FUNC_MUL, 32'd6, 32'd7, 32'd0, 32'd42, 2);

      // Flush together with a request in IDLE: not accepted
      mulalu_sign = 1'b1; mulalu_func = FUNC_MUL; source_a = 32'd9; source_b = 32'd9; flush = 1'b1;
      #1;
      chk("idle_flush stall", {63'd0, stall}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; mulalu_func = FUNC_NONE;
      w = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (hi_write !== 1'b0 || stall !== 1'b0) w++;
         @(posedge clk); #1;
      end
      chk("idle_flush quiet", 64'(w), 64'd0);

      // Flush in DONE suppresses the write
      mulalu_sign = 1'b0; mulalu_func = FUNC_DIV; source_a = 32'd7; source_b = 32'd2;
      for (int c = 0; c < 33; c++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      chk("done_flush strobes", {62'd0, hi_write, lo_write}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; mulalu_func = FUNC_NONE;
      w = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (hi_write !== 1'b0 || lo_write !== 1'b0) w++;
         @(posedge clk); #1;
      end
      chk("done_flush after", 64'(w), 64'd0);

      // Asynchronous reset in cycle 15 of a MUL
      mulalu_sign = 1'b0; mulalu_func = FUNC_MUL; source_a = 32'd3; source_b = 32'd5;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
      end
      #1 rst = 1'b1;
      #1;
      chk("rst_mid stall",   {63'd0, stall}, 64'd0);
      chk("rst_mid strobes", {62'd0, hi_write, lo_write}, 64'd0);
      chk("rst_mid data",    {hi_write_data, lo_write_data}, 64'd0);
      mulalu_func = FUNC_NONE;
      @(posedge clk); #1;
      rst = 1'b0;
      w = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (hi_write !== 1'b0 || lo_write !== 1'b0 || stall !== 1'b0) w++;
         @(posedge clk); #1;
      end
      chk("rst_mid quiet", 64'(w), 64'd0);

      // Random operations against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         rsg = 1'($urandom_range(0, 1));
         rfn = ($urandom_range(0, 1) == 0) ? FUNC_MUL : FUNC_DIV;
         case ($urandom_range(0, 7))
            0: ra = 32'd0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'd1;
            2: rb = 32'hFFFF_FFFF;
            3: rb = $urandom_range(1, 100);
            default: rb = $urandom;
         endcase
         model(rsg, rfn, ra, rb, rhi, rlo);
         run_op($sformatf("rand%0d", i), rsg, rfn, ra, rb, rhi, rlo, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
